// File: rtl/kb_ascii_if.sv
// kb_ascii_if
//   Bundles the two handshake sides of the keyboard translator:
//   - FIFO side : fifo_empty, fifo_data (first-word-fall-through head), rd_fifo (pop strobe)
//   - CPU side  : ascii_data, ascii_valid, ascii_ready (valid/ready transfer)
//   modport master : the translator (consumes FIFO, produces characters)
//   modport slave  : the surroundings (FIFO and CPU consumer)
interface kb_ascii_if;
   logic       fifo_empty;
   logic [8:0] fifo_data;
   logic       rd_fifo;
   logic [7:0] ascii_data;
   logic       ascii_valid;
   logic       ascii_ready;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      input  ascii_ready,
      output rd_fifo,
      output ascii_data,
      output ascii_valid
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      output ascii_ready,
      input  rd_fifo,
      input  ascii_data,
      input  ascii_valid
   );
endinterface

// File: rtl/kb_ascii.sv
// kb_ascii
//   Pops 9-bit make-code entries ({extended, scan code set 2}) from the
//   keyboard receive FIFO and translates each to an 8-bit ASCII/control code.
//   Caps-lock is tracked internally; unmappable entries are counted.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   bus        kb_ascii_if.master: FIFO pop side and CPU valid/ready side
//   caps_lock  current caps-lock state (LED drive)
//   drop_cnt   saturating count of unmapped entries popped
module kb_ascii #(
   parameter int         DROP_CNT_W = 8,
   parameter logic [7:0] ARROW_BASE = 8'h80
) (
   input  logic                  clk,
   input  logic                  rst_n,
   kb_ascii_if.master            bus,
   output logic                  caps_lock,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_XLATE = 2'd1;
   localparam logic [1:0] ST_OUT   = 2'd2;

   localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

   logic [1:0]            state_q, state_d;
   logic [8:0]            code_q, code_d;
   logic [7:0]            ascii_data_q, ascii_data_d;
   logic                  ascii_valid_q, ascii_valid_d;
   logic                  caps_lock_q, caps_lock_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [8:0]            xlate_s;

   // Returns {hit, code}. Letters are looked up as lowercase and shifted to
   // uppercase by clearing bit 5 when caps-lock is on.
   function automatic logic [8:0] xlate(input logic [8:0] code, input logic caps);
      logic       hit;
      logic       letter;
      logic [7:0] ch;
      hit    = 1'b1;
      letter = 1'b0;
      ch     = 8'h00;
      if (code[8]) begin
         case (code[7:0])
            8'h5A:   ch = 8'h0D;
            8'h75:   ch = ARROW_BASE;
            8'h72:   ch = ARROW_BASE + 8'd1;
            8'h6B:   ch = ARROW_BASE + 8'd2;
            8'h74:   ch = ARROW_BASE + 8'd3;
            default: hit = 1'b0;
         endcase
      end else begin
         letter = 1'b1;
         case (code[7:0])
            8'h1C: ch = 8'h61;
            8'h32: ch = 8'h62;
            8'h21: ch = 8'h63;
            8'h23: ch = 8'h64;
            8'h24: ch = 8'h65;
            8'h2B: ch = 8'h66;
            8'h34: ch = 8'h67;
            8'h33: ch = 8'h68;
            8'h43: ch = 8'h69;
            8'h3B: ch = 8'h6A;
            8'h42: ch = 8'h6B;
            8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D;
            8'h31: ch = 8'h6E;
            8'h44: ch = 8'h6F;
            8'h4D: ch = 8'h70;
            8'h15: ch = 8'h71;
            8'h2D: ch = 8'h72;
            8'h1B: ch = 8'h73;
            8'h2C: ch = 8'h74;
            8'h3C: ch = 8'h75;
            8'h2A: ch = 8'h76;
            8'h1D: ch = 8'h77;
            8'h22: ch = 8'h78;
            8'h35: ch = 8'h79;
            8'h1A: ch = 8'h7A;
            default: begin
               letter = 1'b0;
               case (code[7:0])
                  8'h45:   ch = 8'h30;
                  8'h16:   ch = 8'h31;
                  8'h1E:   ch = 8'h32;
                  8'h26:   ch = 8'h33;
                  8'h25:   ch = 8'h34;
                  8'h2E:   ch = 8'h35;
                  8'h36:   ch = 8'h36;
                  8'h3D:   ch = 8'h37;
                  8'h3E:   ch = 8'h38;
                  8'h46:   ch = 8'h39;
                  8'h29:   ch = 8'h20;
                  8'h5A:   ch = 8'h0D;
                  8'h66:   ch = 8'h08;
                  8'h0D:   ch = 8'h09;
                  8'h76:   ch = 8'h1B;
                  default: hit = 1'b0;
               endcase
            end
         endcase
      end
      if (letter && caps) begin
         ch = ch & 8'hDF;
      end else begin
         ch = ch;
      end
      return {hit, ch};
   endfunction

   assign xlate_s = xlate(code_q, caps_lock_q);

   // Pop only from IDLE, so the strobe is at most one cycle wide per entry.
   assign bus.rd_fifo     = (state_q == ST_IDLE) & ~bus.fifo_empty;
   assign bus.ascii_data  = ascii_data_q;
   assign bus.ascii_valid = ascii_valid_q;
   assign caps_lock       = caps_lock_q;
   assign drop_cnt        = drop_cnt_q;

   // Next-state and datapath logic for the IDLE -> XLATE -> OUT sequence.
   always_comb begin
      state_d       = state_q;
      code_d        = code_q;
      ascii_data_d  = ascii_data_q;
      ascii_valid_d = ascii_valid_q;
      caps_lock_d   = caps_lock_q;
      drop_cnt_d    = drop_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (!bus.fifo_empty) begin
               code_d  = bus.fifo_data;
               state_d = ST_XLATE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_XLATE: begin
            if (!code_q[8] && (code_q[7:0] == 8'h58)) begin
               caps_lock_d = ~caps_lock_q;
               state_d     = ST_IDLE;
            end else if (xlate_s[8]) begin
               ascii_data_d  = xlate_s[7:0];
               ascii_valid_d = 1'b1;
               state_d       = ST_OUT;
            end else begin
               if (drop_cnt_q != DROP_MAX) begin
                  drop_cnt_d = drop_cnt_q + DROP_ONE;
               end else begin
                  drop_cnt_d = drop_cnt_q;
               end
               state_d = ST_IDLE;
            end
         end
         ST_OUT: begin
            if (bus.ascii_ready) begin
               ascii_valid_d = 1'b0;
               state_d       = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            ascii_valid_d = 1'b0;
            state_d       = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         code_q        <= 9'h000;
         ascii_data_q  <= 8'h00;
         ascii_valid_q <= 1'b0;
         caps_lock_q   <= 1'b0;
         drop_cnt_q    <= {DROP_CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         code_q        <= code_d;
         ascii_data_q  <= ascii_data_d;
         ascii_valid_q <= ascii_valid_d;
         caps_lock_q   <= caps_lock_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

endmodule
